// File: rtl/sig_gen_pkg.sv
// Shared constants and helpers for the test-signal source: LFSR seed/taps and noise masking.
package sig_gen_pkg;

    localparam int unsigned MASK_W    = 16;
    localparam logic [15:0] LFSR_SEED = 16'hACE1;
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    // Low `level` bits set; any level at or above the sample width yields all ones there.
    function automatic logic [MASK_W-1:0] noise_mask(input logic [3:0] level);
        logic [MASK_W-1:0] m;
        for (int i = 0; i < int'(MASK_W); i++) begin
            m[i] = (i < int'(level));
        end
        return m;
    endfunction

endpackage

// File: rtl/noise_lfsr.sv
// Galois LFSR noise source; advances only on step_i and presents the masked low bits.
module noise_lfsr
    import sig_gen_pkg::*;
#(
    parameter int unsigned LFSR_W = 16,
    parameter int unsigned DATA_W = 8
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              step_i,
    input  logic              noise_en_i,
    input  logic [3:0]        level_i,
    output logic [DATA_W-1:0] noise_o
);
    logic [LFSR_W-1:0] lfsr_q, lfsr_d;
    logic [DATA_W-1:0] mask;

    always_comb begin
        lfsr_d = lfsr_q;
        if (step_i) begin
            lfsr_d = lfsr_q >> 1;
            if (lfsr_q[0]) begin
                lfsr_d = lfsr_d ^ LFSR_W'(LFSR_TAPS);
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            lfsr_q <= LFSR_W'(LFSR_SEED);
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

    assign mask    = DATA_W'(noise_mask(level_i));
    assign noise_o = noise_en_i ? (lfsr_q[DATA_W-1:0] & mask) : '0;

endmodule

// File: rtl/sine_rom.sv
// Combinational sine table, unsigned offset-binary; a parabolic half-wave per half period.
module sine_rom #(
    parameter int unsigned ADDR_W = 10,
    parameter int unsigned DATA_W = 8
) (
    input  logic [ADDR_W-1:0] addr_i,
    output logic [DATA_W-1:0] data_o
);
    localparam int unsigned HALF   = 1 << (ADDR_W - 1);
    localparam int unsigned PROD_W = 2 * (ADDR_W - 1);
    localparam int unsigned SHIFT  = 2 * ADDR_W - 3 - DATA_W;
    localparam int unsigned MAG_W  = DATA_W + 1;
    localparam int unsigned MID    = 1 << (DATA_W - 1);

    logic [ADDR_W-2:0] x;
    logic [PROD_W-1:0] prod;
    logic [MAG_W-1:0]  mag;
    logic [MAG_W-1:0]  hi;
    logic [DATA_W-1:0] lo;

    assign x    = addr_i[ADDR_W-2:0];
    assign prod = PROD_W'(x) * PROD_W'(HALF - int'(x));
    assign mag  = MAG_W'(prod >> SHIFT);
    assign hi   = MAG_W'(MID) + mag;
    assign lo   = DATA_W'(MID) - DATA_W'(mag);

    // Positive peak lands one code above full scale, so clip it.
    always_comb begin
        if (addr_i[ADDR_W-1]) begin
            data_o = lo;
        end else if (hi[DATA_W]) begin
            data_o = '1;
        end else begin
            data_o = hi[DATA_W-1:0];
        end
    end

endmodule

// File: rtl/sig_gen_stream.sv
// Test-signal source: divider-paced phase accumulator into sine_rom, plus bounded noise,
// saturated and streamed over valid/ready with full back-pressure.
module sig_gen_stream
    import sig_gen_pkg::*;
#(
    parameter int unsigned ADDR_W = 10,
    parameter int unsigned FRAC_W = 6,
    parameter int unsigned DATA_W = 8,
    parameter int unsigned OUT_W  = 10,
    parameter int unsigned LFSR_W = 16
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     en_i,
    input  logic [ADDR_W+FRAC_W-1:0] tune_i,
    input  logic [7:0]               div_i,
    input  logic                     noise_en_i,
    input  logic [3:0]               noise_level_i,
    input  logic                     out_ready_i,
    output logic                     out_valid_o,
    output logic [OUT_W-1:0]         signal_o,
    output logic                     wrap_o
);
    localparam int unsigned PH_W   = ADDR_W + FRAC_W;
    localparam int unsigned SUM_W  = DATA_W + 1;
    localparam int unsigned WIDE_W = (SUM_W > OUT_W) ? SUM_W : OUT_W;
    localparam logic [WIDE_W-1:0] SAT_MAX = WIDE_W'({OUT_W{1'b1}});

    logic              stall, tick;
    logic [7:0]        cnt_q, cnt_d;
    logic [PH_W-1:0]   phase_q, phase_d;
    logic              ovf_q, ovf_d;
    logic [PH_W:0]     phase_sum;
    logic [ADDR_W-1:0] addr1_q, addr1_d;
    logic [DATA_W-1:0] noise1_q, noise1_d;
    logic              wrap1_q, wrap1_d, v1_q, v1_d;
    logic              valid_q, valid_d, wrap_q, wrap_d;
    logic [OUT_W-1:0]  signal_q, signal_d;
    logic [DATA_W-1:0] noise, rom_data;
    logic [WIDE_W-1:0] sum_wide;

    assign stall     = valid_q & ~out_ready_i;
    assign tick      = en_i & ~stall & (cnt_q >= div_i);
    assign phase_sum = {1'b0, phase_q} + {1'b0, tune_i};
    assign sum_wide  = WIDE_W'(rom_data) + WIDE_W'(noise1_q);

    // ovf_q remembers the carry of the last increment so wrap tags the first post-wrap sample.
    always_comb begin
        cnt_d    = cnt_q;
        phase_d  = phase_q;
        ovf_d    = ovf_q;
        addr1_d  = addr1_q;
        noise1_d = noise1_q;
        wrap1_d  = wrap1_q;
        v1_d     = v1_q;
        if (!stall) begin
            v1_d = tick;
            if (en_i) begin
                cnt_d = tick ? 8'd0 : cnt_q + 8'd1;
            end
            if (tick) begin
                addr1_d  = phase_q[PH_W-1:FRAC_W];
                noise1_d = noise;
                wrap1_d  = ovf_q;
                ovf_d    = phase_sum[PH_W];
                phase_d  = phase_sum[PH_W-1:0];
            end
        end
    end

    always_comb begin
        valid_d  = valid_q;
        signal_d = signal_q;
        wrap_d   = wrap_q;
        if (!stall) begin
            valid_d = v1_q;
            if (v1_q) begin
                signal_d = (sum_wide > SAT_MAX) ? OUT_W'(SAT_MAX) : OUT_W'(sum_wide);
                wrap_d   = wrap1_q;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q    <= '0;
            phase_q  <= '0;
            ovf_q    <= 1'b0;
            addr1_q  <= '0;
            noise1_q <= '0;
            wrap1_q  <= 1'b0;
            v1_q     <= 1'b0;
            valid_q  <= 1'b0;
            signal_q <= '0;
            wrap_q   <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            phase_q  <= phase_d;
            ovf_q    <= ovf_d;
            addr1_q  <= addr1_d;
            noise1_q <= noise1_d;
            wrap1_q  <= wrap1_d;
            v1_q     <= v1_d;
            valid_q  <= valid_d;
            signal_q <= signal_d;
            wrap_q   <= wrap_d;
        end
    end

    sine_rom #(
        .ADDR_W(ADDR_W),
        .DATA_W(DATA_W)
    ) u_rom (
        .addr_i(addr1_q),
        .data_o(rom_data)
    );

    noise_lfsr #(
        .LFSR_W(LFSR_W),
        .DATA_W(DATA_W)
    ) u_noise (
        .clk_i     (clk_i),
        .rst_ni    (rst_ni),
        .step_i    (tick),
        .noise_en_i(noise_en_i),
        .level_i   (noise_level_i),
        .noise_o   (noise)
    );

    assign out_valid_o = valid_q;
    assign signal_o    = signal_q;
    assign wrap_o      = wrap_q;

endmodule

// File: tb/tb_sig_gen_stream.sv
// Scoreboard bench for sig_gen_stream: a 10-bit and an 8-bit (saturating) instance share stimulus.
module tb_sig_gen_stream;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        en = 1'b1;
    logic [15:0] tune = 16'd64;
    logic [7:0]  div = 8'd0;
    logic        noise_en = 1'b0;
    logic [3:0]  noise_level = 4'd0;
    logic        out_ready = 1'b1;
    logic        out_valid, wrap, out_valid_s, wrap_s;
    logic [9:0]  signal;
    logic [7:0]  signal_s;

    always #5 clk = ~clk;

    sig_gen_stream dut (
        .clk_i(clk), .rst_ni(rst_n), .en_i(en), .tune_i(tune), .div_i(div),
        .noise_en_i(noise_en), .noise_level_i(noise_level), .out_ready_i(out_ready),
        .out_valid_o(out_valid), .signal_o(signal), .wrap_o(wrap)
    );

    sig_gen_stream #(.OUT_W(8)) dut_sat (
        .clk_i(clk), .rst_ni(rst_n), .en_i(en), .tune_i(tune), .div_i(div),
        .noise_en_i(noise_en), .noise_level_i(noise_level), .out_ready_i(out_ready),
        .out_valid_o(out_valid_s), .signal_o(signal_s), .wrap_o(wrap_s)
    );

    typedef struct {
        int unsigned sum;
        bit          wrap;
    } exp_t;

    exp_t        sb[$];
    int          got[$];
    int          got8[$];
    bit          gotw[$];
    int          n_checks = 0;
    int          n_errors = 0;
    int          m_cnt;
    logic [15:0] m_phase, m_lfsr;
    bit          m_ovf, m_v1, m_valid;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    function automatic int rom_ref(input int a);
        int x, s;
        x = a % 512;
        s = (x * (512 - x)) / 512;
        if (a >= 512) return 128 - s;
        return (128 + s > 255) ? 255 : 128 + s;
    endfunction

    function automatic logic [15:0] lfsr_next(input logic [15:0] l);
        return l[0] ? ((l >> 1) ^ 16'hB400) : (l >> 1);
    endfunction

    task automatic model_step();
        exp_t        e;
        logic [16:0] ps;
        int          mask, nz;
        if (m_valid && !out_ready) return;
        m_valid = m_v1;
        m_v1    = 1'b0;
        if (!en) return;
        if (m_cnt >= int'(div)) begin
            mask   = (noise_level >= 4'd8) ? 255 : ((1 << noise_level) - 1);
            nz     = noise_en ? (int'(m_lfsr[7:0]) & mask) : 0;
            ps     = {1'b0, m_phase} + {1'b0, tune};
            e.sum  = rom_ref(int'(m_phase[15:6])) + nz;
            e.wrap = m_ovf;
            sb.push_back(e);
            m_ovf   = ps[16];
            m_phase = ps[15:0];
            m_lfsr  = lfsr_next(m_lfsr);
            m_v1    = 1'b1;
            m_cnt   = 0;
        end else begin
            m_cnt++;
        end
    endtask

    // Called at a falling edge with inputs settled; checks, steps the model, advances one clock.
    task automatic cycle();
        exp_t e;
        check_eq("valid", out_valid, m_valid);
        check_eq("valid_sat", out_valid_s, m_valid);
        if (out_valid) begin
            if (sb.size() == 0) begin
                check_eq("sb_size_at_valid", sb.size(), 1);
            end else begin
                e = sb[0];
                check_eq("signal", signal, (e.sum > 1023) ? 1023 : e.sum);
                check_eq("signal_sat", signal_s, (e.sum > 255) ? 255 : e.sum);
                check_eq("wrap", wrap, e.wrap);
                check_eq("wrap_sat", wrap_s, e.wrap);
                if (out_ready) begin
                    got.push_back(int'(signal));
                    got8.push_back(int'(signal_s));
                    gotw.push_back(wrap);
                    void'(sb.pop_front());
                end
            end
        end
        model_step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        check_eq("rst_valid", out_valid, 0);
        check_eq("rst_signal", signal, 0);
        check_eq("rst_wrap", wrap, 0);
        check_eq("rst_valid_sat", out_valid_s, 0);
        check_eq("rst_signal_sat", signal_s, 0);
        m_cnt = 0; m_phase = '0; m_lfsr = 16'hACE1; m_ovf = 1'b0; m_v1 = 1'b0; m_valid = 1'b0;
        sb.delete(); got.delete(); got8.delete(); gotw.delete();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    initial begin
        int exp_sig[5];
        bit exp_w[5];
        int nv, nwraps, guard;

        @(negedge clk);

        // Plain sweep: one address step per sample, wrap after 1024 samples.
        do_reset();
        cycle();
        check_eq("lat_edge1", out_valid, 0);
        cycle();
        check_eq("lat_edge2", out_valid, 1);
        run(1030);
        check_eq("sweep_first", got[0], 128);
        check_eq("sweep_100", got[100], 208);
        check_eq("sweep_wrap_1023", gotw[1023], 0);
        check_eq("sweep_wrap_1024", gotw[1024], 1);
        nwraps = 0;
        foreach (gotw[i]) if (gotw[i]) nwraps++;
        check_eq("sweep_wrap_count", nwraps, 1);

        // Quarter-turn tuning word.
        tune = 16'd16384;
        do_reset();
        run(8);
        exp_sig = '{128, 255, 128, 0, 128};
        exp_w   = '{0, 0, 0, 0, 1};
        check_eq("quarter_count", got.size() >= 5, 1);
        if (got.size() >= 5) begin
            for (int i = 0; i < 5; i++) begin
                check_eq("quarter_sig", got[i], exp_sig[i]);
                check_eq("quarter_wrap", gotw[i], exp_w[i]);
            end
        end

        // Divider: one sample in four, then drop div while the count is at 2.
        tune = 16'd64;
        div  = 8'd3;
        do_reset();
        nv = 0;
        for (int i = 0; i < 16; i++) begin
            cycle();
            if (out_valid) nv++;
        end
        check_eq("div3_valid_count", nv, 3);
        guard = 0;
        while (m_cnt != 2 && guard < 8) begin
            cycle();
            guard++;
        end
        div = 8'd0;
        cycle();
        cycle();
        check_eq("div_drop_next", out_valid, 1);
        run(4);

        // Noise terms and saturation on the 8-bit instance.
        tune = 16'd0;
        noise_en = 1'b1;
        noise_level = 4'd8;
        do_reset();
        run(6);
        check_eq("noise8_first", got[0], 353);
        check_eq("noise8_second", got[1], 240);
        check_eq("noise8_first_sat", got8[0], 255);
        check_eq("noise8_second_sat", got8[1], 240);
        noise_level = 4'd4;
        do_reset();
        run(4);
        check_eq("noise4_first", got[0], 129);
        noise_level = 4'd0;
        do_reset();
        run(4);
        check_eq("noise0_first", got[0], 128);
        noise_level = 4'd8;
        tune = 16'd12800;
        do_reset();
        run(5);
        check_eq("sat_pre", got[1], 361);
        check_eq("sat_clip", got8[1], 255);

        // Back-pressure: stall mid-stream, then reset during a stall.
        noise_en = 1'b0;
        tune = 16'd64;
        do_reset();
        run(5);
        out_ready = 1'b0;
        run(5);
        out_ready = 1'b1;
        run(10);
        foreach (got[i]) check_eq("bp_seq", got[i], rom_ref(i));
        check_eq("bp_count", got.size(), 13);
        out_ready = 1'b0;
        run(3);
        do_reset();
        out_ready = 1'b1;
        run(4);
        check_eq("bp_restart", got[0], 128);

        // en low: in-flight samples drain, nothing new.
        en = 1'b0;
        run(4);
        check_eq("drain_empty", sb.size(), 0);
        check_eq("drain_idle", out_valid, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
